// File: rtl/pipe_ifu_fq.sv
// pipe_ifu_fq: instruction-fetch unit with PC, in-order variable-latency fetch
// port and a fetch queue drained by ID.
//   clk_i / rst_i             clock, asynchronous active-high reset
//   flush_i, flush_pc_i       redirect request and target (low two bits ignored)
//   imem_req_*                fetch request (valid/ready, word-aligned address)
//   imem_rsp_*                in-order fetch response (always accepted)
//   id_*                      fetch-queue head towards ID (valid/ready)
// Optional feature macro: IFU_PERF_CNT_EN adds perf_fetch_o / perf_stall_o.
module pipe_ifu_fq #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
    parameter int unsigned     FQ_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    output logic            imem_req_valid_o,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_req_ready_i,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    input  logic            imem_rsp_err_i,
    output logic            id_valid_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [31:0]     id_inst_o,
    output logic            id_err_o,
    input  logic            id_ready_i
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_o,
    output logic [31:0]     perf_stall_o
`endif
);

    localparam int unsigned AW = $clog2(FQ_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = CW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic            err;
    } fq_entry_t;

    logic [XLEN-1:0] pc_q;
    logic [CW-1:0]   inflight_q;
    logic [CW-1:0]   drop_q;

    logic [XLEN-1:0] tag_mem_q [FQ_DEPTH];
    logic [AW-1:0]   tag_wr_q;
    logic [AW-1:0]   tag_rd_q;

    fq_entry_t       fq_mem_q [FQ_DEPTH];
    logic [AW-1:0]   fq_wr_q;
    logic [AW-1:0]   fq_rd_q;
    logic [CW-1:0]   fq_cnt_q;

    logic [OW-1:0]   occ_c;
    logic            room_c;
    logic            req_fire_c;
    logic            rsp_ok_c;
    logic            rsp_drop_c;
    logic            rsp_keep_c;
    logic            pop_c;
    fq_entry_t       head_c;
    fq_entry_t       push_c;
    logic            unused_lsb_c;

    // Low PC bits never reach the memory port.
    assign unused_lsb_c = ^{pc_q[1:0], flush_pc_i[1:0]};

    // Every request reserves a queue slot until its word is consumed or dropped.
    assign occ_c  = OW'(inflight_q) + OW'(fq_cnt_q);
    assign room_c = occ_c < OW'(FQ_DEPTH);

    assign imem_req_valid_o = !rst_i && !flush_i && room_c;
    assign imem_req_addr_o  = {pc_q[XLEN-1:2], 2'b00};
    assign req_fire_c       = imem_req_valid_o && imem_req_ready_i;

    // Responses with nothing outstanding are ignored; drop counter squashes stale ones.
    assign rsp_ok_c   = imem_rsp_valid_i && (inflight_q != '0);
    assign rsp_drop_c = rsp_ok_c && (drop_q != '0);
    assign rsp_keep_c = rsp_ok_c && (drop_q == '0);

    assign head_c     = fq_mem_q[fq_rd_q];
    assign id_valid_o = (fq_cnt_q != '0);
    assign id_pc_o    = id_valid_o ? head_c.pc   : '0;
    assign id_inst_o  = id_valid_o ? head_c.inst : '0;
    assign id_err_o   = id_valid_o ? head_c.err  : 1'b0;
    assign pop_c      = id_valid_o && id_ready_i && !flush_i;

    assign push_c = '{pc: tag_mem_q[tag_rd_q], inst: imem_rsp_data_i, err: imem_rsp_err_i};

    // Control state: PC, outstanding/drop counters and FIFO pointers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            fq_wr_q    <= '0;
            fq_rd_q    <= '0;
            fq_cnt_q   <= '0;
        end else if (flush_i) begin
            // Everything still outstanding after this cycle becomes a drop.
            pc_q       <= {flush_pc_i[XLEN-1:2], 2'b00};
            inflight_q <= inflight_q - CW'(rsp_ok_c);
            drop_q     <= inflight_q - CW'(rsp_ok_c);
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            fq_wr_q    <= '0;
            fq_rd_q    <= '0;
            fq_cnt_q   <= '0;
        end else begin
            if (req_fire_c) begin
                pc_q     <= pc_q + XLEN'(4);
                tag_wr_q <= tag_wr_q + AW'(1);
            end
            inflight_q <= inflight_q + CW'(req_fire_c) - CW'(rsp_ok_c);
            if (rsp_drop_c) begin
                drop_q <= drop_q - CW'(1);
            end
            if (rsp_keep_c) begin
                tag_rd_q <= tag_rd_q + AW'(1);
                fq_wr_q  <= fq_wr_q + AW'(1);
            end
            if (pop_c) begin
                fq_rd_q <= fq_rd_q + AW'(1);
            end
            fq_cnt_q <= fq_cnt_q + CW'(rsp_keep_c) - CW'(pop_c);
        end
    end

    // Storage arrays; contents are only observed through valid pointers.
    always_ff @(posedge clk_i) begin
        if (req_fire_c) begin
            tag_mem_q[tag_wr_q] <= imem_req_addr_o;
        end
        if (rsp_keep_c && !flush_i) begin
            fq_mem_q[fq_wr_q] <= push_c;
        end
    end

`ifdef IFU_PERF_CNT_EN
    // Delivery and starvation counters; survive flushes, wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_fetch_o <= '0;
            perf_stall_o <= '0;
        end else begin
            if (pop_c) begin
                perf_fetch_o <= perf_fetch_o + 32'd1;
            end
            if (id_ready_i && !id_valid_o) begin
                perf_stall_o <= perf_stall_o + 32'd1;
            end
        end
    end
`endif

    rsp_needs_inflight: assert property (@(posedge clk_i) disable iff (rst_i)
        !(imem_rsp_valid_i && (inflight_q == '0)));

endmodule

// File: tb/tb_pipe_ifu_fq.sv
// Bench for pipe_ifu_fq: random memory/ID/flush traffic against an epoch-based
// reference model, with an ID-side scoreboard monitor.
module tb_pipe_ifu_fq;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = '0;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i = 1'b0;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = '0;
    logic        imem_rsp_err_i = 1'b0;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_err_o;
    logic        id_ready_i = 1'b0;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
`endif

    pipe_ifu_fq #(.XLEN(32), .RESET_PC(RST_PC), .FQ_DEPTH(DEPTH)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .flush_pc_i       (flush_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .imem_rsp_err_i   (imem_rsp_err_i),
        .id_valid_o       (id_valid_o),
        .id_pc_o          (id_pc_o),
        .id_inst_o        (id_inst_o),
        .id_err_o         (id_err_o),
        .id_ready_i       (id_ready_i)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_o     (perf_fetch),
        .perf_stall_o     (perf_stall)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          epoch;
        int          due;
    } mem_t;

    exp_t        exp_q[$];
    mem_t        mem_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          epoch = 0;
    logic [31:0] m_pc = RST_PC;
    int          m_fetch = 0;
    int          m_stall = 0;
    int          nreq = 0;
    int          first_fire = -1;
    int          first_valid = -1;
    int          flush_at = -1;
    logic [31:0] flush_at_pc = '0;
    int          lat_min = 1, lat_max = 1, p_rready = 100, p_rsp = 100, p_idready = 100, p_flush = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic knobs(input int lmin, input int lmax, input int rr, input int rs,
                         input int ir, input int fl);
        lat_min = lmin; lat_max = lmax; p_rready = rr; p_rsp = rs; p_idready = ir; p_flush = fl;
    endtask

    task automatic drive_idle();
        flush_i = 1'b0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i = '0;
        imem_rsp_err_i = 1'b0;
        id_ready_i = 1'b0;
    endtask

    // Asynchronous reset asserted between edges, memory side cleared with it.
    task automatic do_reset();
        @(negedge clk_i);
        #3;
        rst_i = 1'b1;
        drive_idle();
        mem_q.delete();
        exp_q.delete();
        m_pc = RST_PC;
        epoch = 0;
        m_fetch = 0;
        m_stall = 0;
        first_fire = -1;
        first_valid = -1;
        flush_at = -1;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_req_valid", 64'(imem_req_valid_o), 64'd0);
        check("rst_req_addr", 64'(imem_req_addr_o), 64'(RST_PC));
        check("rst_id_valid", 64'(id_valid_o), 64'd0);
        check("rst_id_fields", {id_pc_o, id_inst_o} | 64'(id_err_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // One quiet cycle with no events, then compare the performance counters.
    task automatic idle();
        @(negedge clk_i);
        drive_idle();
        #1;
`ifdef IFU_PERF_CNT_EN
        check("perf_fetch", 64'(perf_fetch), 64'(m_fetch));
        check("perf_stall", 64'(perf_stall), 64'(m_stall));
`endif
    endtask

    task automatic run(input int n);
        mem_t it;
        logic exp_rv;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            cyc++;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc && ($urandom % 100) < p_rsp) begin
                imem_rsp_valid_i = 1'b1;
                imem_rsp_data_i  = mem_q[0].data;
                imem_rsp_err_i   = mem_q[0].err;
            end else begin
                imem_rsp_valid_i = 1'b0;
                imem_rsp_data_i  = '0;
                imem_rsp_err_i   = 1'b0;
            end
            imem_req_ready_i = (($urandom % 100) < p_rready);
            id_ready_i       = (($urandom % 100) < p_idready);
            if (cyc == flush_at) begin
                flush_i    = 1'b1;
                flush_pc_i = flush_at_pc;
            end else begin
                flush_i = (($urandom % 1000) < p_flush);
                if (($urandom % 4) == 0) flush_pc_i = 32'hFFFF_FFF0 + ($urandom % 16);
                else                     flush_pc_i = 32'h8000_1000 + ($urandom % 256);
            end
            #1;
            // Request side: a slot is free unless issued-but-unconsumed words fill the queue.
            exp_rv = !flush_i && ((mem_q.size() + exp_q.size()) < DEPTH);
            check("req_valid", 64'(imem_req_valid_o), 64'(exp_rv));
            if (imem_req_valid_o) check("req_addr", 64'(imem_req_addr_o), 64'({m_pc[31:2], 2'b00}));
            if (id_ready_i && !id_valid_o) m_stall++;
            if (id_ready_i && id_valid_o && !flush_i) m_fetch++;
            if (id_valid_o && first_valid < 0) first_valid = cyc;
            if (imem_rsp_valid_i) begin
                it = mem_q.pop_front();
                if (!flush_i && it.epoch == epoch)
                    exp_q.push_back('{pc: it.addr, inst: it.data, err: it.err});
            end
            if (imem_req_valid_o && imem_req_ready_i) begin
                mem_q.push_back('{addr: {m_pc[31:2], 2'b00}, data: $urandom, err: (($urandom % 8) == 0),
                                  epoch: epoch, due: cyc + lat_min + int'($urandom % (lat_max - lat_min + 1))});
                m_pc = m_pc + 32'd4;
                nreq++;
                if (first_fire < 0) first_fire = cyc;
            end
            if (flush_i) begin
                exp_q.delete();
                epoch++;
                m_pc = {flush_pc_i[31:2], 2'b00};
            end
        end
    endtask

    // Scoreboard monitor: compares every word ID accepts, and idle-output zeroing.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (!rst_i) begin
                if (!id_valid_o) begin
                    check("id_idle_zero", 64'((id_pc_o != '0) || (id_inst_o != '0) || id_err_o), 64'd0);
                end else if (id_ready_i && !flush_i) begin
                    if (exp_q.size() == 0) begin
                        check("id_unexpected", 64'(id_pc_o), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("id_pc", 64'(id_pc_o), 64'(e.pc));
                        check("id_inst", 64'(id_inst_o), 64'(e.inst));
                        check("id_err", 64'(id_err_o), 64'(e.err));
                    end
                end
            end
        end
    end

    initial begin
        do_reset();

        // Sequential fetch with single-cycle memory; first word two cycles after request.
        knobs(1, 1, 100, 100, 100, 0);
        run(12);
        check("first_id_latency", 64'(first_valid - first_fire), 64'd2);
        idle();

        // ID stalled: the queue fills to exactly its depth and fetch stops.
        do_reset();
        knobs(1, 1, 100, 100, 0, 0);
        nreq = 0;
        run(20);
        check("stall_req_count", 64'(nreq), 64'd4);
        check("stall_queue_fill", 64'(exp_q.size()), 64'd4);
        knobs(1, 1, 100, 100, 100, 0);
        run(10);
        idle();

        // Flush to a misaligned target with two fetches outstanding on 3-cycle memory.
        do_reset();
        knobs(3, 3, 100, 100, 100, 0);
        flush_at    = cyc + 3;
        flush_at_pc = 32'h8000_1002;
        run(20);
        idle();

        // Memory refuses requests: address must hold and no fetch issues.
        do_reset();
        knobs(1, 2, 0, 100, 100, 0);
        nreq = 0;
        run(10);
        check("blocked_req_count", 64'(nreq), 64'd0);
        knobs(1, 2, 100, 100, 100, 0);
        run(10);
        idle();

        // Random traffic, mild and heavy flushing, then a mid-operation reset.
        knobs(1, 4, 60, 70, 60, 15);
        run(3000);
        idle();
        knobs(1, 3, 80, 80, 80, 80);
        run(3000);
        idle();
        do_reset();
        knobs(1, 5, 70, 60, 50, 20);
        run(2000);
        idle();

        // Drain: no new requests, everything outstanding must reach ID.
        knobs(1, 1, 0, 100, 100, 0);
        run(40);
        idle();
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("drain_mem_empty", 64'(mem_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
